// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: synchronise, debounce and edge-detect panel keys and the code bus.
// Long-press detector on btn6 is built only when PANEL_LONG_PRESS_EN is defined.
module panel_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 4000,
  parameter int unsigned SW_STABLE_CYCLES  = 4000,
  parameter int unsigned LONG_PRESS_CYCLES = 1000000,
  parameter int unsigned CNT_W             = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw7,
  input  logic       start,
  input  logic       btn6,
  input  logic [6:0] sw_input,
  output logic       power_on,
  output logic       start_pulse,
  output logic       confirm_pulse,
  output logic [6:0] sw_code,
  output logic       sw_update,
  output logic       long_press
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SwLast = CNT_W'(SW_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  if (((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) ||
      ((64'(1) << CNT_W) <= 64'(SW_STABLE_CYCLES)) ||
      ((64'(1) << CNT_W) <= 64'(LONG_PRESS_CYCLES))) begin : g_cnt_w_chk
    $error("CNT_W too narrow for cycle parameters");
  end

  // key channel index: 0 = sw7 (power), 1 = start, 2 = btn6
  logic [2:0]            key_s1_q, key_s2_q;
  logic [2:0]            deb_q, deb_d, deb_dly_q;
  logic [2:0][CNT_W-1:0] kcnt_q, kcnt_d;

  logic [6:0]            bus_s1_q, bus_s2_q, bus_prev_q;
  logic [CNT_W-1:0]      sw_cnt_q, sw_cnt_d;
  logic [6:0]            sw_code_q, sw_code_d;
  logic                  bus_stable, bus_load;

  logic start_pulse_q, start_pulse_d;
  logic confirm_pulse_q, confirm_pulse_d;
  logic sw_update_q, sw_update_d;

  always_comb begin
    deb_d  = deb_q;
    kcnt_d = kcnt_q;
    for (int i = 0; i < 3; i++) begin
      if (key_s2_q[i] == deb_q[i]) begin
        kcnt_d[i] = '0;
      end else if (kcnt_q[i] >= DbLast) begin
        deb_d[i]  = key_s2_q[i];
        kcnt_d[i] = '0;
      end else begin
        kcnt_d[i] = kcnt_q[i] + One;
      end
    end
  end

  assign start_pulse_d   = deb_q[1] & ~deb_dly_q[1] & deb_q[0];
  assign confirm_pulse_d = deb_q[2] & ~deb_dly_q[2] & deb_q[0];

  // sw_code follows the bus even when powered off; only the pulse is gated
  assign bus_stable  = (bus_s2_q == bus_prev_q);
  assign bus_load    = bus_stable && (sw_cnt_q >= SwLast) &&
                       (bus_s2_q != sw_code_q);
  assign sw_cnt_d    = !bus_stable          ? '0 :
                       (sw_cnt_q >= SwLast) ? sw_cnt_q :
                                              sw_cnt_q + One;
  assign sw_code_d   = bus_load ? bus_s2_q : sw_code_q;
  assign sw_update_d = bus_load & deb_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q        <= '0;
      key_s2_q        <= '0;
      deb_q           <= '0;
      deb_dly_q       <= '0;
      kcnt_q          <= '0;
      bus_s1_q        <= '0;
      bus_s2_q        <= '0;
      bus_prev_q      <= '0;
      sw_cnt_q        <= '0;
      sw_code_q       <= '0;
      start_pulse_q   <= 1'b0;
      confirm_pulse_q <= 1'b0;
      sw_update_q     <= 1'b0;
    end else begin
      key_s1_q        <= {btn6, start, sw7};
      key_s2_q        <= key_s1_q;
      deb_q           <= deb_d;
      deb_dly_q       <= deb_q;
      kcnt_q          <= kcnt_d;
      bus_s1_q        <= sw_input;
      bus_s2_q        <= bus_s1_q;
      bus_prev_q      <= bus_s2_q;
      sw_cnt_q        <= sw_cnt_d;
      sw_code_q       <= sw_code_d;
      start_pulse_q   <= start_pulse_d;
      confirm_pulse_q <= confirm_pulse_d;
      sw_update_q     <= sw_update_d;
    end
  end

  assign power_on      = deb_q[0];
  assign start_pulse   = start_pulse_q;
  assign confirm_pulse = confirm_pulse_q;
  assign sw_code       = sw_code_q;
  assign sw_update     = sw_update_q;

`ifdef PANEL_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LpMax  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LpLast = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             lp_hold;
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
  logic             long_press_q, long_press_d;

  // counter parks at LpMax so the pulse fires once per debounced hold
  assign lp_hold      = deb_q[2] & deb_q[0];
  assign lp_cnt_d     = !lp_hold          ? '0 :
                        (lp_cnt_q < LpMax) ? lp_cnt_q + One :
                                             lp_cnt_q;
  assign long_press_d = lp_hold && (lp_cnt_q == LpLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt_q     <= '0;
      long_press_q <= 1'b0;
    end else begin
      lp_cnt_q     <= lp_cnt_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press = long_press_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner with scaled-down cycle parameters.
// Stimulus pushes expected events with cycle windows; a negedge monitor pops and checks them.
module tb_panel_input_conditioner;

  localparam int D  = 400;
  localparam int S  = 400;
  localparam int LP = 3000;

  localparam int K_POW   = 0;
  localparam int K_START = 1;
  localparam int K_CONF  = 2;
  localparam int K_UPD   = 3;
  localparam int K_LP    = 4;

  typedef struct {
    int         kind;
    int         lo;
    int         hi;
    logic [6:0] val;
  } ev_t;

  ev_t sb[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw7, start, btn6;
  logic [6:0] sw_input;
  logic       power_on, start_pulse, confirm_pulse, sw_update, long_press;
  logic [6:0] sw_code;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic prev_pow = 1'b0;

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SW_STABLE_CYCLES(S),
    .LONG_PRESS_CYCLES(LP),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw7(sw7),
    .start(start),
    .btn6(btn6),
    .sw_input(sw_input),
    .power_on(power_on),
    .start_pulse(start_pulse),
    .confirm_pulse(confirm_pulse),
    .sw_code(sw_code),
    .sw_update(sw_update),
    .long_press(long_press)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_POW:   return "power_on";
      K_START: return "start_pulse";
      K_CONF:  return "confirm_pulse";
      K_UPD:   return "sw_update";
      default: return "long_press";
    endcase
  endfunction

  task automatic push(input int kind, input int centre, input logic [6:0] val);
    ev_t e;
    e.kind = kind;
    e.lo   = centre - 1;
    e.hi   = centre + 1;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic take(input int kind, input logic [6:0] act);
    int idx = -1;
    n_tests++;
    foreach (sb[i]) if (idx < 0 && sb[i].kind == kind) idx = i;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event at cycle %0d value %h, required none",
               kname(kind), cyc, act);
    end else begin
      if (cyc < sb[idx].lo || cyc > sb[idx].hi || act !== sb[idx].val) begin
        n_fail++;
        $display("FAIL %s: got cycle %0d value %h, required cycle %0d..%0d value %h",
                 kname(kind), cyc, act, sb[idx].lo, sb[idx].hi, sb[idx].val);
      end
      sb.delete(idx);
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pow = 1'b0;
    end else begin
      if (power_on !== prev_pow) begin
        take(K_POW, {6'b0, power_on});
        prev_pow = power_on;
      end
      if (start_pulse)   take(K_START, 7'd1);
      if (confirm_pulse) take(K_CONF, 7'd1);
      if (sw_update)     take(K_UPD, sw_code);
      if (long_press)    take(K_LP, 7'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {4'b0, power_on, start_pulse, confirm_pulse, sw_code, sw_update, long_press};
  endfunction

  initial begin
    rst_n = 1'b0;
    sw7 = 1'b0;
    start = 1'b0;
    btn6 = 1'b0;
    sw_input = 7'h00;
    tick(5);
    check("reset_outputs", outs(), 16'h0);

    rst_n = 1'b1;
    sw7 = 1'b1;
    push(K_POW, cyc + D + 2, 7'd1);
    tick(1000);
    check("power_up_level", {15'b0, power_on}, 16'h1);

    // reset in the middle of a btn6 hold
    btn6 = 1'b1;
    tick(200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs(), 16'h0);
    tick(5);
    rst_n = 1'b1;
    push(K_POW, cyc + D + 2, 7'd1);
    push(K_CONF, cyc + D + 3, 7'd1);
    tick(600);
    btn6 = 1'b0;
    tick(600);

    // clean press, no pulse on release
    btn6 = 1'b1;
    push(K_CONF, cyc + D + 3, 7'd1);
    tick(600);
    btn6 = 1'b0;
    tick(600);

    // bounce gap inside a press, then a short start glitch
    btn6 = 1'b1;
    push(K_CONF, cyc + D + 3, 7'd1);
    tick(600);
    btn6 = 1'b0;
    tick(50);
    btn6 = 1'b1;
    tick(600);
    btn6 = 1'b0;
    tick(600);
    start = 1'b1;
    tick(300);
    start = 1'b0;
    tick(600);

    // code bus
    sw_input = 7'b1010110;
    push(K_UPD, cyc + S + 3, 7'h56);
    tick(600);
    check("sw_code_56", {9'b0, sw_code}, 16'h0056);
    for (int i = 0; i < 8; i++) begin
      sw_input[0] = ~sw_input[0];
      tick(100);
    end
    tick(600);
    check("sw_code_after_toggle", {9'b0, sw_code}, 16'h0056);
    sw_input = 7'h2B;
    push(K_UPD, cyc + S + 3, 7'h2B);
    tick(600);

    // power gating
    sw7 = 1'b0;
    push(K_POW, cyc + D + 2, 7'd0);
    tick(600);
    check("power_off_level", {15'b0, power_on}, 16'h0);
    sw_input = 7'h11;
    start = 1'b1;
    tick(600);
    check("sw_code_unpowered", {9'b0, sw_code}, 16'h0011);
    sw7 = 1'b1;
    push(K_POW, cyc + D + 2, 7'd1);
    tick(600);
    start = 1'b0;
    tick(600);

    // long btn6 hold
    btn6 = 1'b1;
    push(K_CONF, cyc + D + 3, 7'd1);
`ifdef PANEL_LONG_PRESS_EN
    push(K_LP, cyc + D + 2 + LP, 7'd1);
`endif
    tick(D + LP + 300);
    btn6 = 1'b0;
    tick(600);
    check("long_press_idle", {15'b0, long_press}, 16'h0);

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: missing event, required in cycles %0d..%0d value %h",
               kname(sb[i].kind), sb[i].lo, sb[i].hi, sb[i].val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/panel_input_conditioner.md
# panel_input_conditioner

Front-panel input conditioner for the bomb-defusal game. Sits between the raw board inputs (power switch `sw7`, `start` key, confirm key `btn6`, 7-bit code switches `sw_input`) and the game controller. It synchronises, debounces and edge-detects the panel controls, so the controller only ever sees clean levels and single-cycle command pulses.

## Interface
- `DEBOUNCE_CYCLES`, 4000: consecutive cycles a key or power-switch level must differ from its debounced value before it is accepted (4 ms at 1 MHz).
- `SW_STABLE_CYCLES`, 4000: cycles the `sw_input` bus must hold unchanged before it is accepted.
- `LONG_PRESS_CYCLES`, 1000000: debounced `btn6` hold time for a long press (only used with `PANEL_LONG_PRESS_EN`).
- `CNT_W`, 20: counter width. Must satisfy 2^CNT_W > max of the three cycle parameters.

Ports:
- `clk` in 1: system clock (1 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `sw7` in 1: raw power switch.
- `start` in 1: raw start key, active high.
- `btn6` in 1: raw confirm key, active high.
- `sw_input` in 7: raw code switches.
- `power_on` out 1: debounced `sw7` level.
- `start_pulse` out 1: one-cycle pulse on the debounced rising edge of `start`.
- `confirm_pulse` out 1: one-cycle pulse on the debounced rising edge of `btn6`.
- `sw_code` out 7: accepted (stable) switch code.
- `sw_update` out 1: one-cycle pulse when `sw_code` changes.
- `long_press` out 1: one-cycle pulse on a long press of `btn6`.

## Operation
- Every raw input passes through a 2-FF synchroniser. The synchronisers reset to 0.
- **Key/switch channels** (`sw7`, `start`, `btn6`), each with its own counter:
  - When the synced value equals the debounced value, the counter is cleared.
  - Otherwise the counter increments.
  - When the count reaches `DEBOUNCE_CYCLES-1` while the values still differ, the debounced value takes the synced value and the counter clears.
  - Any return to agreement before that point clears the counter. Glitches shorter than `DEBOUNCE_CYCLES` are therefore discarded, and short release gaps inside a press are absorbed.
- **Pulses:**
  - `start_pulse` and `confirm_pulse` are registered and asserted for exactly one cycle, on the cycle after the debounced value goes 0→1.
  - Both pulses are suppressed while `power_on`=0. A press already debounced high when power comes up produces no pulse.
- **Code bus:**
  - The synced bus is compared with its value from the previous cycle. Any bit change clears the stability counter.
  - When the bus has been unchanged for `SW_STABLE_CYCLES` cycles and differs from `sw_code`, `sw_code` is loaded and `sw_update` pulses for one cycle.
  - A stable value equal to `sw_code` causes no pulse.
  - `sw_code` tracks the bus regardless of `power_on`. `sw_update` is suppressed while `power_on`=0.
- **Simultaneous events:** `start_pulse`, `confirm_pulse` and `sw_update` may assert in the same cycle. The block applies no priority; the game controller arbitrates.
- **Counters:** all counters saturate and never wrap.

## Timing
- Reset: all outputs, debounced values, counters and synchronisers go to 0 immediately when `rst_n` falls (asynchronous). Reset release is synchronous to `clk`.
- Reset mid-press: after release, the key must again be held `DEBOUNCE_CYCLES` cycles before it is accepted. An in-flight count is lost.
- Latency from a raw key edge to the debounced level change is `DEBOUNCE_CYCLES`+2 cycles, with ±1 cycle for input sampling phase. The pulse follows one cycle later.
- Latency from the last raw bus change to `sw_code`/`sw_update` is `SW_STABLE_CYCLES`+3 cycles, ±1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PANEL_LONG_PRESS_EN` defined:
  - A hold counter runs while debounced `btn6`=1 and `power_on`=1.
  - When it reaches `LONG_PRESS_CYCLES`, `long_press` pulses once. There is no repeat until `btn6` is released (debounced).
  - `confirm_pulse` behaviour is unchanged.
- `PANEL_LONG_PRESS_EN` undefined: the hold counter is not built and `long_press` is tied to 0.

## Test plan
All scenarios use default parameters and `sw7` held high for 10000 cycles before the test unless stated otherwise.
- Reset: pull `rst_n` low mid-press, at 2000 cycles into a `btn6` hold → all outputs 0 in the same cycle. After release with `btn6` still held, `confirm_pulse` comes 4002–4004 cycles later.
- Clean press: `btn6` high for 6000 cycles → exactly one `confirm_pulse`, 1 cycle wide, 4003±1 cycles after the press. No second pulse on release.
- Bounce: `btn6` high 6000, low 500, high 6000 → exactly one `confirm_pulse`. A 3000-cycle glitch on `start` → no `start_pulse`.
- Power gating: with `sw7`=0, press `start` for 6000 cycles → no pulse. Raise `sw7` → `power_on`=1 after 4002±1 cycles, still no `start_pulse`.
- Code bus: `sw_input` 0→7'b1010110, held → `sw_code`=7'h56 and one `sw_update` 4003±1 cycles later. Toggle bit 0 every 1000 cycles → no update. Return to 7'h56 → no pulse.
- Long press, with `PANEL_LONG_PRESS_EN` defined: hold `btn6` for 1200000 cycles → one `confirm_pulse`, then one `long_press` 1000000 cycles after the debounced rise. Without the macro, `long_press` stays 0.
